// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop driver.
//   state_t   : sequencer states (IDLE, DRIVE, CHECK)
//   MODE_SR   : excitation policy set/reset/hold
//   MODE_TOG  : excitation policy toggle/hold
//   jk_excite : {j,k} needed to move a JK flip-flop from q to tgt
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic MODE_SR  = 1'b0;
   localparam logic MODE_TOG = 1'b1;

   // Returns {j,k}. A target equal to the current Q yields 2'b00 in both
   // policies, so the flip-flop simply holds.
   function automatic logic [1:0] jk_excite(input logic tgt,
                                            input logic q,
                                            input logic mode);
      logic d;
      d = tgt ^ q;
      if (mode == MODE_TOG) begin
         return {d, d};
      end
      return {tgt & ~q, ~tgt & q};
   endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// 1-bit wide target FIFO, DEPTH entries (power of two, >= 2).
//   clk, rst   : clock, asynchronous active-low reset
//   push/push_data : write request (ignored while full)
//   pop/pop_data   : read request (ignored while empty), head is pop_data
//   full/empty     : occupancy flags
//   level          : current occupancy, 0..DEPTH
module jk_tgt_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     push_data,
   input  logic                     pop,
   output logic                     pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (level == FULL_LVL);
   assign empty    = (level == '0);
   // Full blocks a push even when a pop happens in the same cycle.
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // NOTE: storage carries no reset; only pointers and level define validity,
   // so stale bits are never observable.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/jk_ff_driver.sv
// Sequencer driving an external JK flip-flop from a queue of desired Q values.
// Each target: pop in IDLE and load the J/K excitation, hold it for one DRIVE
// cycle, then compare the flip-flop output in CHECK and report pass/fail.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready/in_target : target stream (ready = FIFO not full)
//   mode              : 0 set/reset/hold, 1 toggle/hold; sampled at pop
//   q_fb              : Q of the driven flip-flop, same clock domain
//   j, k              : registered excitation
//   busy              : sequencer active or targets pending
//   chk_valid/chk_ok  : one-cycle check result
//   err_cnt           : saturating count of failed checks
//   fifo_level        : current FIFO occupancy
module jk_ff_driver
   import jk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_target,
   input  logic                     mode,
   input  logic                     q_fb,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic                     chk_valid,
   output logic                     chk_ok,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam logic [CNT_W-1:0] ERR_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic             tgt;
   logic             tgt_nxt;
   logic             j_nxt;
   logic             k_nxt;
   logic             chk_valid_nxt;
   logic             chk_ok_nxt;
   logic [CNT_W-1:0] err_cnt_nxt;
   logic             pop;
   logic             head;
   logic             fifo_full;
   logic             fifo_empty;

   jk_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid),
      .push_data (in_target),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign in_ready = ~fifo_full;
   assign busy     = (state != IDLE) | ~fifo_empty;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt     = state;
      tgt_nxt       = tgt;
      j_nxt         = 1'b0;
      k_nxt         = 1'b0;
      chk_valid_nxt = 1'b0;
      chk_ok_nxt    = chk_ok;
      err_cnt_nxt   = err_cnt;
      pop           = 1'b0;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop              = 1'b1;
               tgt_nxt          = head;
               {j_nxt, k_nxt}   = jk_excite(head, q_fb, mode);
               state_nxt        = DRIVE;
            end
         end
         DRIVE: begin
            // Flip-flop captures j/k on this edge; drop them back to hold.
            state_nxt = CHECK;
         end
         CHECK: begin
            chk_valid_nxt = 1'b1;
            chk_ok_nxt    = (q_fb == tgt);
            if ((q_fb != tgt) && (err_cnt != ERR_MAX)) begin
               err_cnt_nxt = err_cnt + 1'b1;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tgt       <= 1'b0;
         j         <= 1'b0;
         k         <= 1'b0;
         chk_valid <= 1'b0;
         chk_ok    <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         tgt       <= tgt_nxt;
         j         <= j_nxt;
         k         <= k_nxt;
         chk_valid <= chk_valid_nxt;
         chk_ok    <= chk_ok_nxt;
         err_cnt   <= err_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_jk_ff_driver.sv
// Self-checking bench for jk_ff_driver: behavioural JK flip-flop on q_fb,
// table-driven target sequences, and a scoreboard of expected drive/check
// results popped on every chk_valid.
module tb_jk_ff_driver;

   typedef struct {
      logic tgt;
      logic ej;
      logic ek;
      logic eok;
   } exp_t;

   typedef struct {
      logic mode;
      logic tgt;
      logic ej;
      logic ek;
      logic eok;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rst2 = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_target = 1'b0;
   logic       mode = 1'b0;
   logic       stuck = 1'b0;
   logic       ff_q;
   logic       q_fb;

   logic       in_ready, j, k, busy, chk_valid, chk_ok;
   logic [7:0] err_cnt;
   logic [2:0] fifo_level;

   logic       in_ready2, j2, k2, busy2, chk_valid2, chk_ok2;
   logic [1:0] err_cnt2;
   logic [2:0] fifo_level2;

   int         n_tests = 0;
   int         n_fail = 0;
   int         n_chk = 0;
   int         peak_lvl = 0;
   logic       saw_not_ready = 1'b0;
   logic       ready_chk_en = 1'b0;
   logic [1:0] jk_d1 = 2'b00;
   logic [1:0] jk_d2 = 2'b00;
   exp_t       sb[$];
   vec_t       vecs[7];

   always #5 clk = ~clk;

   jk_ff_driver #(.DEPTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_target  (in_target),
      .mode       (mode),
      .q_fb       (q_fb),
      .j          (j),
      .k          (k),
      .busy       (busy),
      .chk_valid  (chk_valid),
      .chk_ok     (chk_ok),
      .err_cnt    (err_cnt),
      .fifo_level (fifo_level)
   );

   // Narrow counter instance with Q stuck at 0, used for saturation.
   jk_ff_driver #(.DEPTH(4), .CNT_W(2)) dut2 (
      .clk        (clk),
      .rst        (rst2),
      .in_valid   (in_valid),
      .in_ready   (in_ready2),
      .in_target  (in_target),
      .mode       (mode),
      .q_fb       (1'b0),
      .j          (j2),
      .k          (k2),
      .busy       (busy2),
      .chk_valid  (chk_valid2),
      .chk_ok     (chk_ok2),
      .err_cnt    (err_cnt2),
      .fifo_level (fifo_level2)
   );

   // Behavioural JK flip-flop on the same clock.
   always @(posedge clk or negedge rst) begin
      if (!rst) ff_q <= 1'b0;
      else begin
         case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end

   assign q_fb = stuck ? 1'b0 : ff_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: j/k seen two negedges before chk_valid belong to that target.
   always @(negedge clk) begin
      if (rst) begin
         if (sb.size() == 0) begin
            check("no chk_valid without target", chk_valid, 0);
         end else if (chk_valid) begin
            check("chk_ok", chk_ok, sb[0].eok);
            check("drive j", jk_d2[1], sb[0].ej);
            check("drive k", jk_d2[0], sb[0].ek);
            void'(sb.pop_front());
            n_chk <= n_chk + 1;
         end
         if (ready_chk_en) begin
            check("in_ready vs level", in_ready, fifo_level != 3'd4);
            if (int'(fifo_level) > peak_lvl) peak_lvl <= int'(fifo_level);
            if (!in_ready) saw_not_ready <= 1'b1;
         end
         jk_d2 <= jk_d1;
         jk_d1 <= {j, k};
      end else begin
         jk_d2 <= 2'b00;
         jk_d1 <= 2'b00;
      end
   end

   function automatic exp_t exp_of(input logic t, input logic m, input logic q, input logic st);
      exp_t e;
      e.tgt = t;
      if (m) begin
         e.ej = (t != q);
         e.ek = (t != q);
      end else begin
         e.ej = t && !q;
         e.ek = !t && q;
      end
      e.eok = st ? (t == 1'b0) : 1'b1;
      return e;
   endfunction

   // Present a target (called at a negedge); record it once accepted.
   task automatic send(input logic t, input exp_t rec);
      bit ok = 1'b0;
      in_valid  = 1'b1;
      in_target = t;
      for (int c = 0; c < 100 && !ok; c++) begin
         if (in_ready) begin
            sb.push_back(rec);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      if (!ok) check("push accepted", 0, 1);
   endtask

   task automatic drain();
      for (int c = 0; c < 300; c++) begin
         if (sb.size() == 0 && !busy) break;
         @(negedge clk);
      end
      @(negedge clk);
      check("drain completes", (sb.size() == 0) && !busy, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      logic mq;
      logic bt[8];

      vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      bt = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset held with in_valid asserted.
      rst = 1'b0;
      in_valid = 1'b1;
      in_target = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset j", j, 0);
         check("reset k", k, 0);
         check("reset fifo_level", fifo_level, 0);
         check("reset err_cnt", err_cnt, 0);
         check("reset chk_valid", chk_valid, 0);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("in_ready after reset", in_ready, 1);
      @(negedge clk);
      check("idle after reset", busy, 0);

      // Set/reset sequence from Q=0.
      mode = 1'b0;
      base = n_chk;
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].tgt, '{vecs[i].tgt, vecs[i].ej, vecs[i].ek, vecs[i].eok});
      end
      in_valid = 1'b0;
      drain();
      check("sr check count", n_chk - base, 4);
      check("sr err_cnt", err_cnt, 0);

      // Toggle sequence from Q=0.
      do_reset();
      mode = 1'b1;
      base = n_chk;
      for (int i = 4; i < 7; i++) begin
         send(vecs[i].tgt, '{vecs[i].tgt, vecs[i].ej, vecs[i].ek, vecs[i].eok});
      end
      in_valid = 1'b0;
      drain();
      check("tog check count", n_chk - base, 3);
      check("tog err_cnt", err_cnt, 0);

      // Burst faster than the pop rate to fill the FIFO.
      do_reset();
      mode = 1'b0;
      mq = 1'b0;
      base = n_chk;
      ready_chk_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(bt[i], exp_of(bt[i], 1'b0, mq, 1'b0));
         mq = bt[i];
      end
      in_valid = 1'b0;
      drain();
      ready_chk_en = 1'b0;
      check("burst peak level", peak_lvl, 4);
      check("burst saw in_ready low", saw_not_ready, 1);
      check("burst check count", n_chk - base, 8);

      // Stuck-at-0 feedback: every target of 1 fails.
      do_reset();
      rst2 = 1'b1;
      stuck = 1'b1;
      for (int i = 0; i < 3; i++) send(1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b1));
      in_valid = 1'b0;
      drain();
      check("fault err_cnt 3", err_cnt, 3);
      check("fault narrow err_cnt 3", err_cnt2, 3);
      for (int i = 0; i < 2; i++) send(1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b1));
      in_valid = 1'b0;
      drain();
      check("fault err_cnt 5", err_cnt, 5);
      check("narrow err_cnt saturates", err_cnt2, 3);
      stuck = 1'b0;

      // Reset during DRIVE discards the in-flight target.
      do_reset();
      check("err_cnt cleared", err_cnt, 0);
      mode = 1'b0;
      send(1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (j) break;
         @(negedge clk);
      end
      check("mid j driven", j, 1);
      #2;
      rst = 1'b0;
      sb.delete();
      #1;
      check("async reset clears j", j, 0);
      check("async reset level", fifo_level, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("post reset level", fifo_level, 0);
      check("post reset in_ready", in_ready, 1);
      repeat (4) @(negedge clk);
      base = n_chk;
      send(1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b0;
      drain();
      check("post reset check count", n_chk - base, 1);
      check("post reset err_cnt", err_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
